// File: rtl/seq_det_ctrl.sv
// Run-time bit-serial sequence detector: programmable pattern, overlap mode,
// match limit and sample window, armed by start and ended by limit/window/abort.
module seq_det_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             overlap_i,
    input  logic [WIN_W-1:0] window_i,
    input  logic [CNT_W-1:0] max_match_i,
    input  logic             signal_i,
    output logic             busy_o,
    output logic             match_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             done_o,
    output logic             timeout_o
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q, hist_q, hist_d;
    logic             ovl_q;
    logic [WIN_W-1:0] win_q, bits_q, bits_d;
    logic [CNT_W-1:0] max_q, cnt_q, cnt_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             busy_q, match_q, done_q, timeout_q;
    logic             hit, lim_hit, win_hit;

    // Candidate next values for a sampling edge in SEARCH.
    always_comb begin
        hist_d  = {hist_q[PAT_W-2:0], signal_i};
        fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
        bits_d  = bits_q + WIN_W'(1);
        hit     = (fill_d == FILL_FULL) && (hist_d == pat_q);
        cnt_d   = (hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        lim_hit = hit && (max_q != '0) && (cnt_d == max_q);
        win_hit = (win_q != '0) && (bits_d == win_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
            win_q     <= '0;
            max_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            bits_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            match_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        pat_q     <= pattern_i;
                        ovl_q     <= overlap_i;
                        win_q     <= window_i;
                        max_q     <= max_match_i;
                        hist_q    <= '0;
                        fill_q    <= '0;
                        bits_q    <= '0;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (abort_i) begin
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        hist_q  <= hist_d;
                        // Non-overlapping mode demands PAT_W fresh bits after each hit.
                        fill_q  <= (hit && !ovl_q) ? '0 : fill_d;
                        bits_q  <= bits_d;
                        match_q <= hit;
                        cnt_q   <= cnt_d;
                        if (lim_hit || win_hit) begin
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            timeout_q <= win_hit && !lim_hit;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign match_o     = match_q;
    assign match_cnt_o = cnt_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: a vector table for whole runs plus
// hand-written sequences for mid-run reset and start-while-busy.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, sig = 1'b0, overlap = 1'b0;
    logic [3:0]  pattern = '0;
    logic [15:0] window = '0;
    logic [7:0]  max_match = '0;
    logic        busy, match, done, timeout;
    logic [7:0]  match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_ctrl #(.PAT_W(4), .CNT_W(8), .WIN_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .pattern_i(pattern), .overlap_i(overlap), .window_i(window),
        .max_match_i(max_match), .signal_i(sig), .busy_o(busy),
        .match_o(match), .match_cnt_o(match_cnt), .done_o(done),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pat;
        logic        ovl;
        logic [15:0] win;
        logic [7:0]  maxm;
    } cfg_t;

    typedef struct {
        int         cfg;
        logic       st, ab, sg;
        logic       busy, match;
        logic [7:0] cnt;
        logic       done, to;
    } vec_t;

    cfg_t cfgs[5];
    vec_t vecs[$];

    function automatic void add(int c, logic st, logic ab, logic sg,
                                logic b, logic m, logic [7:0] n, logic d, logic t);
        vec_t v;
        v.cfg = c; v.st = st; v.ab = ab; v.sg = sg;
        v.busy = b; v.match = m; v.cnt = n; v.done = d; v.to = t;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic b, logic m, logic [7:0] n, logic d, logic t);
        chk({tag, " busy"}, 16'(busy), 16'(b));
        chk({tag, " match"}, 16'(match), 16'(m));
        chk({tag, " cnt"}, 16'(match_cnt), 16'(n));
        chk({tag, " done"}, 16'(done), 16'(d));
        chk({tag, " timeout"}, 16'(timeout), 16'(t));
    endtask

    task automatic drv(logic st, logic ab, logic sg);
        start = st; abort = ab; sig = sg;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(int c);
        pattern = cfgs[c].pat; overlap = cfgs[c].ovl;
        window = cfgs[c].win; max_match = cfgs[c].maxm;
    endtask

    initial begin
        cfgs[0] = '{4'b1001, 1'b1, 16'd0, 8'd0};
        cfgs[1] = '{4'b1001, 1'b0, 16'd0, 8'd0};
        cfgs[2] = '{4'b1001, 1'b1, 16'd6, 8'd0};
        cfgs[3] = '{4'b1001, 1'b1, 16'd7, 8'd2};
        cfgs[4] = '{4'b1001, 1'b1, 16'd0, 8'd1};

        // overlapping: matches after bits 4 and 7, then abort; abort in IDLE is inert
        add(0,1,0,0, 1,0,0,0,0);
        add(0,0,0,1, 1,0,0,0,0); add(0,0,0,0, 1,0,0,0,0); add(0,0,0,0, 1,0,0,0,0);
        add(0,0,0,1, 1,1,1,0,0); add(0,0,0,0, 1,0,1,0,0); add(0,0,0,0, 1,0,1,0,0);
        add(0,0,0,1, 1,1,2,0,0);
        add(0,0,1,0, 0,0,2,1,0);
        add(0,0,1,0, 0,0,2,0,0);
        // non-overlapping: only one match
        add(1,1,0,0, 1,0,0,0,0);
        add(1,0,0,1, 1,0,0,0,0); add(1,0,0,0, 1,0,0,0,0); add(1,0,0,0, 1,0,0,0,0);
        add(1,0,0,1, 1,1,1,0,0); add(1,0,0,0, 1,0,1,0,0); add(1,0,0,0, 1,0,1,0,0);
        add(1,0,0,1, 1,0,1,0,0);
        add(1,0,1,0, 0,0,1,1,0);
        add(1,0,0,0, 0,0,1,0,0);
        // window expiry after 6 samples, timeout held in IDLE
        add(2,1,0,0, 1,0,0,0,0);
        for (int i = 0; i < 5; i++) add(2,0,0,1, 1,0,0,0,0);
        add(2,0,0,1, 0,0,0,1,1);
        add(2,0,0,0, 0,0,0,0,1);
        add(2,0,0,0, 0,0,0,0,1);
        // limit and window coincide on bit 7: limit wins; start in DONE ignored
        add(3,1,0,0, 1,0,0,0,0);
        add(3,0,0,1, 1,0,0,0,0); add(3,0,0,0, 1,0,0,0,0); add(3,0,0,0, 1,0,0,0,0);
        add(3,0,0,1, 1,1,1,0,0); add(3,0,0,0, 1,0,1,0,0); add(3,0,0,0, 1,0,1,0,0);
        add(3,0,0,1, 0,1,2,1,0);
        add(3,1,0,0, 0,0,2,0,0);
        add(3,0,0,0, 0,0,2,0,0);
        // limit of one, no window
        add(4,1,0,0, 1,0,0,0,0);
        add(4,0,0,1, 1,0,0,0,0); add(4,0,0,0, 1,0,0,0,0); add(4,0,0,0, 1,0,0,0,0);
        add(4,0,0,1, 0,1,1,1,0);
        add(4,0,0,0, 0,0,1,0,0);

        // reset state
        set_cfg(0);
        drv(0, 0, 0);
        drv(1, 1, 1);
        chk_all("reset", 0, 0, 8'd0, 0, 0);
        rst_n = 1'b1;
        drv(0, 0, 0);
        chk_all("post-reset idle", 0, 0, 8'd0, 0, 0);

        foreach (vecs[i]) begin
            set_cfg(vecs[i].cfg);
            drv(vecs[i].st, vecs[i].ab, vecs[i].sg);
            chk_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].match,
                    vecs[i].cnt, vecs[i].done, vecs[i].to);
        end

        // reset mid-SEARCH with a nonzero count and a primed history
        set_cfg(0);
        drv(1, 0, 0);
        drv(0, 0, 1); drv(0, 0, 0); drv(0, 0, 0); drv(0, 0, 1);
        chk_all("pre-reset match", 1, 1, 8'd1, 0, 0);
        drv(0, 0, 0); drv(0, 0, 0);
        rst_n = 1'b0;
        drv(0, 0, 1);
        chk_all("mid-run reset", 0, 0, 8'd0, 0, 0);
        rst_n = 1'b1;
        drv(1, 0, 0);
        chk("restart busy", 16'(busy), 16'd1);
        drv(0, 0, 1);
        chk("restart bit1 match", 16'(match), 16'd0);
        drv(0, 0, 0); drv(0, 0, 0);
        chk("restart bit3 match", 16'(match), 16'd0);
        drv(0, 0, 1);
        chk_all("restart bit4", 1, 1, 8'd1, 0, 0);
        drv(0, 1, 0);
        chk_all("restart abort", 0, 0, 8'd1, 1, 0);
        drv(0, 0, 0);

        // start while busy with a different pattern is ignored
        set_cfg(0);
        drv(1, 0, 0);
        drv(0, 0, 1);
        pattern = 4'b0110;
        drv(1, 0, 0);
        chk("busy start ignored", 16'(busy), 16'd1);
        drv(0, 0, 0);
        drv(0, 0, 1);
        chk_all("orig pattern hit", 1, 1, 8'd1, 0, 0);
        drv(0, 0, 1); drv(0, 0, 0);
        chk_all("new pattern no hit", 1, 0, 8'd1, 0, 0);
        drv(0, 1, 0);
        chk_all("busy-start abort", 0, 0, 8'd1, 1, 0);
        drv(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
